// File: rtl/jtag_master_pkg.sv
// Shared types and sequence constants for the JTAG master.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_TLR = 2'd0,
        OP_IR  = 2'd1,
        OP_DR  = 2'd2,
        OP_RTI = 2'd3
    } jtag_op_e;

    typedef enum logic [2:0] {
        IDLE,
        AUTO_TLR,
        PREAMBLE,
        SHIFT,
        POSTAMBLE,
        RESP
    } jtag_state_e;

    localparam int TLR_LEN    = 6;
    localparam int IR_PRE_LEN = 4;
    localparam int DR_PRE_LEN = 3;
    localparam int POST_LEN   = 2;

    // Number of TCK cycles that walk the TAP from Run-Test/Idle into a shift state.
    function automatic logic [6:0] pre_len(jtag_op_e op);
        return (op == OP_IR) ? 7'(IR_PRE_LEN) : 7'(DR_PRE_LEN);
    endfunction

    // TMS level for TCK cycle idx of the given phase.
    function automatic logic phase_tms(jtag_state_e st, logic [6:0] idx,
                                       jtag_op_e op, logic [6:0] len);
        logic tms;
        tms = 1'b0;
        case (st)
            AUTO_TLR:  tms = (idx < 7'(TLR_LEN - 1));
            PREAMBLE:  tms = (op == OP_IR) ? (idx < 7'd2) : (idx == 7'd0);
            SHIFT:     tms = (op != OP_RTI) && (idx == len - 7'd1);
            POSTAMBLE: tms = (idx == 7'd0);
            default:   tms = 1'b0;
        endcase
        return tms;
    endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// TCK generator: divides clk by CLK_DIV per half period while run is high.
// The rise/fall strobes mark the clk cycle whose closing edge moves TCK.
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap     = run && (cnt == 8'(CLK_DIV - 1));
    assign tck_rise = wrap && !tck;
    assign tck_fall = wrap && tck;

    // Half-period counter; TCK parks low whenever no command is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
            tck <= 1'b0;
        end else if (!run) begin
            cnt <= 8'd0;
            tck <= 1'b0;
        end else if (wrap) begin
            cnt <= 8'd0;
            tck <= ~tck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: executes TLR / IR scan / DR scan / RTI-idle commands on a TAP
// chain, one command in flight, returning captured TDO bits per command.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    output logic               jtag_trst_n,
    input  logic               jtag_tdo
);

    jtag_state_e        state, state_n;
    jtag_op_e           op_q, op_n;
    logic [6:0]         idx, idx_n;
    logic [6:0]         len_q, len_n;
    logic [MAX_LEN-1:0] data_sr, data_n;
    logic [MAX_LEN-1:0] cap_q, cap_n;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_n;
    logic               rsp_err_q, rsp_err_n;
    logic               tap_known, tap_known_n;
    logic               tms_q, tms_n;
    logic               tdi_q, tdi_n;
    logic               trst_n_q;
    logic               run;
    logic               tck_rise, tck_fall;

    assign run         = (state == AUTO_TLR) || (state == PREAMBLE) ||
                         (state == SHIFT) || (state == POSTAMBLE);
    assign cmd_ready   = (state == IDLE) && trst_n_q;
    assign rsp_valid   = (state == RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign jtag_tms    = tms_q;
    assign jtag_tdi    = tdi_q;
    assign jtag_trst_n = trst_n_q;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .tck      (jtag_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    // State and datapath registers; reset parks the TAP pins and forgets the TAP state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= OP_TLR;
            idx        <= 7'd0;
            len_q      <= 7'd0;
            data_sr    <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tap_known  <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            trst_n_q   <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            idx        <= idx_n;
            len_q      <= len_n;
            data_sr    <= data_n;
            cap_q      <= cap_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            tap_known  <= tap_known_n;
            tms_q      <= tms_n;
            tdi_q      <= tdi_n;
            trst_n_q   <= 1'b1;
        end
    end

    // Command sequencing; phases advance on TCK falling strobes, TDO is captured on rising ones.
    always_comb begin
        state_n     = state;
        op_n        = op_q;
        idx_n       = idx;
        len_n       = len_q;
        data_n      = data_sr;
        cap_n       = cap_q;
        rsp_data_n  = rsp_data_q;
        rsp_err_n   = rsp_err_q;
        tap_known_n = tap_known;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_n       = jtag_op_e'(cmd_op);
                    len_n      = cmd_len;
                    data_n     = cmd_data;
                    cap_n      = '0;
                    idx_n      = 7'd0;
                    rsp_data_n = '0;
                    rsp_err_n  = 1'b0;
                    if ((op_n == OP_IR || op_n == OP_DR) &&
                        (cmd_len == 7'd0 || int'(cmd_len) > MAX_LEN)) begin
                        rsp_err_n = 1'b1;
                        state_n   = RESP;
                    end else if (op_n == OP_RTI && cmd_len == 7'd0) begin
                        state_n = RESP;
                    end else if (op_n == OP_TLR || !tap_known) begin
                        state_n = AUTO_TLR;
                    end else if (op_n == OP_RTI) begin
                        state_n = SHIFT;
                    end else begin
                        state_n = PREAMBLE;
                    end
                end
            end
            AUTO_TLR: begin
                if (tck_fall) begin
                    if (idx == 7'(TLR_LEN - 1)) begin
                        idx_n       = 7'd0;
                        tap_known_n = 1'b1;
                        if (op_q == OP_TLR) begin
                            state_n = RESP;
                        end else if (op_q == OP_RTI) begin
                            state_n = SHIFT;
                        end else begin
                            state_n = PREAMBLE;
                        end
                    end else begin
                        idx_n = idx + 7'd1;
                    end
                end
            end
            PREAMBLE: begin
                if (tck_fall) begin
                    if (idx == pre_len(op_q) - 7'd1) begin
                        idx_n   = 7'd0;
                        state_n = SHIFT;
                    end else begin
                        idx_n = idx + 7'd1;
                    end
                end
            end
            SHIFT: begin
                if (tck_rise && op_q != OP_RTI) begin
                    cap_n = {jtag_tdo, cap_q[MAX_LEN-1:1]};
                end
                if (tck_fall) begin
                    data_n = data_sr >> 1;
                    if (idx == len_q - 7'd1) begin
                        idx_n   = 7'd0;
                        state_n = (op_q == OP_RTI) ? RESP : POSTAMBLE;
                    end else begin
                        idx_n = idx + 7'd1;
                    end
                end
            end
            POSTAMBLE: begin
                if (tck_fall) begin
                    if (idx == 7'(POST_LEN - 1)) begin
                        state_n    = RESP;
                        rsp_data_n = cap_q >> (MAX_LEN - int'(len_q));
                    end else begin
                        idx_n = idx + 7'd1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pin levels for the upcoming TCK cycle; they only move at command start or on a falling strobe.
    always_comb begin
        tms_n = tms_q;
        tdi_n = 1'b0;
        if (state_n == AUTO_TLR || state_n == PREAMBLE ||
            state_n == SHIFT || state_n == POSTAMBLE) begin
            tms_n = phase_tms(state_n, idx_n, op_n, len_n);
            tdi_n = (state_n == SHIFT && op_n != OP_RTI) ? data_n[0] : 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master: a behavioural model lists the TMS/TDI
// bits expected at every TCK rise and the TDO bits returned during shifts.
module tb_jtag_master;

    localparam int CLK_DIV = 3;
    localparam int MAX_LEN = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = 2'd0;
    logic [6:0]         cmd_len = 7'd0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
    logic               jtag_tdo = 1'b0;

    int  checks = 0;
    int  errors = 0;
    bit  known = 1'b0;
    bit  tdo_q[$];
    bit  obs_tms[$];
    bit  obs_tdi[$];
    int  rise_cnt = 0;
    int  cyc = 0;
    int  last_rise_cyc = 0;
    int  period_err = 0;
    int  proto_err = 0;
    logic prev_tck = 1'b0;
    logic prev_tms = 1'b1;
    logic prev_tdi = 1'b0;

    always #5 clk = ~clk;

    jtag_master #(
        .CLK_DIV (CLK_DIV),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .jtag_tck    (jtag_tck),
        .jtag_tms    (jtag_tms),
        .jtag_tdi    (jtag_tdi),
        .jtag_trst_n (jtag_trst_n),
        .jtag_tdo    (jtag_tdo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Free-running clk cycle counter used to measure the TCK period.
    always @(posedge clk) cyc = cyc + 1;

    // Pin monitor: records TMS/TDI at each TCK rise, checks pin timing, plays back TDO.
    always @(negedge clk) begin
        if (!rst) begin
            if (jtag_tck && !prev_tck) begin
                obs_tms.push_back(jtag_tms);
                obs_tdi.push_back(jtag_tdi);
                if (rise_cnt > 0 && (cyc - last_rise_cyc) != 2 * CLK_DIV) period_err++;
                last_rise_cyc = cyc;
                rise_cnt++;
            end
            if (jtag_tck && prev_tck && (jtag_tms !== prev_tms || jtag_tdi !== prev_tdi)) proto_err++;
        end
        prev_tck = jtag_tck;
        prev_tms = jtag_tms;
        prev_tdi = jtag_tdi;
        jtag_tdo = (rise_cnt < tdo_q.size()) ? tdo_q[rise_cnt] : 1'b0;
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pins"},
                    {57'd0, jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n, cmd_ready, rsp_valid, rsp_err},
                    64'b0100000);
        checkOutput({tag, "_rsp_data"}, rsp_data, 64'd0);
    endtask

    // Issues one command, then checks the pin sequence and response against the model.
    // stall > 0 holds rsp_ready low that many cycles; abort_at > 0 resets mid-command.
    task automatic applyStimulus(input logic [1:0] op, input logic [6:0] len,
                                 input logic [63:0] data, input logic [63:0] pattern,
                                 input int stall, input int abort_at);
        bit          e_tms[$];
        bit          e_tdi[$];
        bit          e_shift[$];
        logic [63:0] exp_data;
        logic [63:0] snap;
        bit          exp_err;
        int          k, n, rc, bad_v, bad_d, bad_r, tms_bad, tdi_bad;

        exp_err = (op == 2'd1 || op == 2'd2) && (len == 7'd0 || int'(len) > MAX_LEN);
        if (!exp_err && !(op == 2'd3 && len == 7'd0)) begin
            if (op == 2'd0 || !known) begin
                for (int i = 0; i < 6; i++) begin
                    e_tms.push_back(i < 5); e_tdi.push_back(1'b0); e_shift.push_back(1'b0);
                end
            end
            if (op == 2'd1) begin
                e_tms.push_back(1'b1); e_tms.push_back(1'b1);
                e_tms.push_back(1'b0); e_tms.push_back(1'b0);
                repeat (4) begin e_tdi.push_back(1'b0); e_shift.push_back(1'b0); end
            end
            if (op == 2'd2) begin
                e_tms.push_back(1'b1); e_tms.push_back(1'b0); e_tms.push_back(1'b0);
                repeat (3) begin e_tdi.push_back(1'b0); e_shift.push_back(1'b0); end
            end
            if (op == 2'd1 || op == 2'd2) begin
                for (int i = 0; i < int'(len); i++) begin
                    e_tms.push_back(i == int'(len) - 1); e_tdi.push_back(data[i]); e_shift.push_back(1'b1);
                end
                e_tms.push_back(1'b1); e_tms.push_back(1'b0);
                repeat (2) begin e_tdi.push_back(1'b0); e_shift.push_back(1'b0); end
            end
            if (op == 2'd3) begin
                for (int i = 0; i < int'(len); i++) begin
                    e_tms.push_back(1'b0); e_tdi.push_back(1'b0); e_shift.push_back(1'b0);
                end
            end
        end

        tdo_q.delete();
        exp_data = 64'd0;
        k = 0;
        foreach (e_shift[j]) begin
            if (e_shift[j]) begin
                tdo_q.push_back(pattern[k]);
                exp_data[k] = pattern[k];
                k++;
            end else begin
                tdo_q.push_back(1'($urandom));
            end
        end

        @(negedge clk);
        obs_tms.delete();
        obs_tdi.delete();
        rise_cnt   = 0;
        period_err = 0;
        proto_err  = 0;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 64'd0, 64'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        if (abort_at > 0) begin
            n = 0;
            while (rise_cnt < abort_at && n < 5000) begin @(negedge clk); n++; end
            @(posedge clk);
            #2 rst = 1'b1;
            #1 checkResetState("abort");
            bad_v = 0;
            repeat (5) begin @(negedge clk); if (rsp_valid) bad_v++; end
            checkOutput("abort_no_rsp", 64'(bad_v), 64'd0);
            rst   = 1'b0;
            known = 1'b0;
            tdo_q.delete();
            return;
        end

        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 4000);
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 64'd0, 64'd1);
            return;
        end

        if (stall > 0) begin
            snap  = rsp_data;
            rc    = rise_cnt;
            bad_v = 0; bad_d = 0; bad_r = 0;
            repeat (stall) begin
                @(negedge clk);
                if (!rsp_valid) bad_v++;
                if (rsp_data !== snap) bad_d++;
                if (cmd_ready) bad_r++;
            end
            checkOutput("stall_valid", 64'(bad_v), 64'd0);
            checkOutput("stall_data", 64'(bad_d), 64'd0);
            checkOutput("stall_ready", 64'(bad_r), 64'd0);
            checkOutput("stall_tck", 64'(rise_cnt - rc), 64'd0);
        end

        tms_bad = 0;
        tdi_bad = 0;
        for (int j = 0; j < e_tms.size() && j < obs_tms.size(); j++) begin
            if (obs_tms[j] != e_tms[j]) tms_bad++;
            if (obs_tdi[j] != e_tdi[j]) tdi_bad++;
        end
        checkOutput("rsp_data", rsp_data, exp_data);
        checkOutput("rsp_err", 64'(rsp_err), 64'(exp_err));
        checkOutput("tck_count", 64'(obs_tms.size()), 64'(e_tms.size()));
        checkOutput("tms_seq", 64'(tms_bad), 64'd0);
        checkOutput("tdi_seq", 64'(tdi_bad), 64'd0);
        checkOutput("tck_period", 64'(period_err), 64'd0);
        checkOutput("pin_timing", 64'(proto_err), 64'd0);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("rsp_release", {62'd0, rsp_valid, cmd_ready}, 64'b01);
        if (e_tms.size() > 0) known = 1'b1;
    endtask

    // Runaway guard so the bench always ends.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized command mix.
    initial begin
        logic [1:0]  r_op;
        logic [6:0]  r_len;
        int          r;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(posedge clk);
        #1 checkOutput("post_reset", {62'd0, jtag_trst_n, cmd_ready}, 64'b11);

        applyStimulus(2'd2, 7'd32, 64'd0, 64'hA92434CF, 0, 0);
        applyStimulus(2'd1, 7'd13, 64'h1FFF, 64'h0001, 0, 0);
        applyStimulus(2'd2, 7'd3, 64'h5, 64'h0, 0, 0);
        applyStimulus(2'd2, 7'd0, 64'h3, 64'hF, 0, 0);
        applyStimulus(2'd2, 7'd65, 64'h3, 64'hF, 0, 0);
        applyStimulus(2'd1, 7'd0, 64'h1, 64'h1, 0, 0);
        applyStimulus(2'd3, 7'd0, 64'h0, 64'h0, 0, 0);
        applyStimulus(2'd3, 7'd10, 64'hFFFF, {$urandom, $urandom}, 0, 0);
        applyStimulus(2'd2, 7'd16, {$urandom, $urandom}, {$urandom, $urandom}, 20, 0);
        applyStimulus(2'd0, 7'd0, 64'h0, 64'h0, 0, 0);
        applyStimulus(2'd2, 7'd64, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);
        applyStimulus(2'd2, 7'd40, {$urandom, $urandom}, {$urandom, $urandom}, 0, 20);
        applyStimulus(2'd2, 7'd24, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);

        for (int i = 0; i < 14; i++) begin
            r     = int'($urandom_range(0, 9));
            r_op  = 2'($urandom_range(0, 3));
            r_len = 7'($urandom_range(1, 64));
            if (r == 0) r_len = 7'd0;
            if (r == 1) r_len = 7'($urandom_range(65, 127));
            applyStimulus(r_op, r_len, {$urandom, $urandom}, {$urandom, $urandom},
                          (r == 2) ? 5 : 0, 0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
